// File: rtl/clk_step_pkg.sv
// Shared constants, width helpers and mode encoding for the clock-enable
// front end and its debouncer.
package clk_step_pkg;

    localparam int DEF_FAST_DIV     = 50000;
    localparam int DEF_SLOW_DIV     = 25000000;
    localparam int DEF_LIGHT_DIV    = 500000;
    localparam int DEF_DEBOUNCE_CYC = 1000000;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_STEP = 1'b1
    } mode_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_step_gen_if.sv
// Board-side controls and the enable strobes handed to the CPU and display.
interface clk_step_gen_if;

    logic SW_choose;
    logic SW_run;
    logic key_step_n;
    logic halt;
    logic cpu_ce;
    logic light_ce;
    logic step_led;
    logic quick_low_led;

    modport master (
        output SW_choose, SW_run, key_step_n, halt,
        input  cpu_ce, light_ce, step_led, quick_low_led
    );

    modport slave (
        input  SW_choose, SW_run, key_step_n, halt,
        output cpu_ce, light_ce, step_led, quick_low_led
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability filter for the active-low step key;
// emits a single-cycle pulse when a press is accepted.
module key_debounce
    import clk_step_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             key_s1_q, key_s1_d;
    logic             key_s2_q, key_s2_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic             accepted_q, accepted_d;
    logic             press_q, press_d;

    always_comb begin
        key_s1_d     = key_n;
        key_s2_d     = key_s1_q;
        accepted_d   = accepted_q;
        stable_cnt_d = stable_cnt_q + CNT_W'(1);
        // Any sample matching the accepted level restarts the stability window.
        if (key_s2_q == accepted_q) begin
            stable_cnt_d = '0;
        end else if (stable_cnt_q == STABLE_LAST) begin
            stable_cnt_d = '0;
            accepted_d   = key_s2_q;
        end
        press_d = accepted_q & ~accepted_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1_q     <= 1'b0;
            key_s2_q     <= 1'b0;
            stable_cnt_q <= '0;
            accepted_q   <= 1'b1;
            press_q      <= 1'b0;
        end else begin
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            stable_cnt_q <= stable_cnt_d;
            accepted_q   <= accepted_d;
            press_q      <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clk_step_gen.sv
// Produces single-cycle CPU and display enables from one board clock, with a
// switch-selected CPU rate and a debounced single-step key.
module clk_step_gen
    import clk_step_pkg::*;
#(
    parameter int FAST_DIV     = DEF_FAST_DIV,
    parameter int SLOW_DIV     = DEF_SLOW_DIV,
    parameter int LIGHT_DIV    = DEF_LIGHT_DIV,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_step_gen_if.slave bus
);

    localparam int CPU_W   = cnt_width(max_int(FAST_DIV, SLOW_DIV));
    localparam int LIGHT_W = cnt_width(LIGHT_DIV);
    localparam logic [CPU_W-1:0]   FAST_TC  = CPU_W'(FAST_DIV - 1);
    localparam logic [CPU_W-1:0]   SLOW_TC  = CPU_W'(SLOW_DIV - 1);
    localparam logic [LIGHT_W-1:0] LIGHT_TC = LIGHT_W'(LIGHT_DIV - 1);
    localparam int SW_CHOOSE = 0;
    localparam int SW_RUN    = 1;

    logic [1:0]         sw_s1_q, sw_s1_d;
    logic [1:0]         sw_s2_q, sw_s2_d;
    logic [1:0]         sw_prev_q, sw_prev_d;
    logic [CPU_W-1:0]   cpu_cnt_q, cpu_cnt_d;
    logic [LIGHT_W-1:0] light_cnt_q, light_cnt_d;
    logic               cpu_ce_q, cpu_ce_d;
    logic               light_ce_q, light_ce_d;
    logic               step_led_q, step_led_d;
    logic               quick_q, quick_d;

    logic               key_press;
    mode_e              mode;
    logic [CPU_W-1:0]   cpu_tc;
    logic               restart;
    logic               div_tick;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.key_step_n),
        .press (key_press)
    );

    always_comb begin
        sw_s1_d   = {bus.SW_run, bus.SW_choose};
        sw_s2_d   = sw_s1_q;
        sw_prev_d = sw_s2_q;

        mode    = sw_s2_q[SW_RUN] ? MODE_RUN : MODE_STEP;
        cpu_tc  = sw_s2_q[SW_CHOOSE] ? FAST_TC : SLOW_TC;
        // A rate or mode change restarts the period with no strobe that cycle.
        restart = (mode == MODE_STEP) || (sw_s2_q != sw_prev_q);

        div_tick  = 1'b0;
        cpu_cnt_d = cpu_cnt_q + CPU_W'(1);
        if (restart) begin
            cpu_cnt_d = '0;
        end else if (cpu_cnt_q >= cpu_tc) begin
            cpu_cnt_d = '0;
            div_tick  = 1'b1;
        end

        light_ce_d  = (light_cnt_q == LIGHT_TC);
        light_cnt_d = light_ce_d ? '0 : light_cnt_q + LIGHT_W'(1);

        // halt drops the strobe outright; nothing is remembered for later.
        cpu_ce_d   = !bus.halt && ((mode == MODE_STEP) ? key_press : div_tick);
        step_led_d = (mode == MODE_STEP);
        quick_d    = sw_s2_q[SW_CHOOSE];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            sw_prev_q   <= '0;
            cpu_cnt_q   <= '0;
            light_cnt_q <= '0;
            cpu_ce_q    <= 1'b0;
            light_ce_q  <= 1'b0;
            step_led_q  <= 1'b0;
            quick_q     <= 1'b0;
        end else begin
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            sw_prev_q   <= sw_prev_d;
            cpu_cnt_q   <= cpu_cnt_d;
            light_cnt_q <= light_cnt_d;
            cpu_ce_q    <= cpu_ce_d;
            light_ce_q  <= light_ce_d;
            step_led_q  <= step_led_d;
            quick_q     <= quick_d;
        end
    end

    assign bus.cpu_ce        = cpu_ce_q;
    assign bus.light_ce      = light_ce_q;
    assign bus.step_led      = step_led_q;
    assign bus.quick_low_led = quick_q;

endmodule

// File: tb/tb_clk_step_gen.sv
// Directed and random stimulus for clk_step_gen, checked every cycle against a
// cycle-count reference model built from the behavioural rules.
module tb_clk_step_gen;

    localparam int FD = 4;
    localparam int SD = 10;
    localparam int LD = 3;
    localparam int DB = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_step_gen_if bus ();

    clk_step_gen #(
        .FAST_DIV     (FD),
        .SLOW_DIV     (SD),
        .LIGHT_DIV    (LD),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int ce_count = 0;

    // Reference model: pins reach the logic two edges late; the CPU strobe is
    // a function of cycles elapsed since the last restart; a key level is
    // accepted once the last DB synchronized samples all disagree with it.
    bit run_pipe[$];
    bit cho_pipe[$];
    bit key_pipe[$];
    bit win[$];
    bit rs_last, cs_last, acc, press_prev;
    int k, elapsed;
    bit e_cpu, e_light, e_step, e_quick;

    function automatic void model_reset();
        run_pipe = '{1'b0, 1'b0};
        cho_pipe = '{1'b0, 1'b0};
        key_pipe = '{1'b0, 1'b0};
        win.delete();
        rs_last = 1'b0;
        cs_last = 1'b0;
        acc = 1'b1;
        press_prev = 1'b0;
        k = 0;
        elapsed = 0;
        e_cpu = 1'b0;
        e_light = 1'b0;
        e_step = 1'b0;
        e_quick = 1'b0;
    endfunction

    function automatic void model_edge();
        bit rs, cs, ks, tick_now, all_opp, press_now;
        if (!rst_n) begin
            model_reset();
            return;
        end
        k++;
        rs = run_pipe.pop_front();
        run_pipe.push_back(bus.SW_run);
        cs = cho_pipe.pop_front();
        cho_pipe.push_back(bus.SW_choose);
        ks = key_pipe.pop_front();
        key_pipe.push_back(bus.key_step_n);

        tick_now = 1'b0;
        if (!rs || rs != rs_last || cs != cs_last) begin
            elapsed = 0;
        end else begin
            elapsed++;
            tick_now = (elapsed % (cs ? FD : SD)) == 0;
        end
        e_cpu   = !bus.halt && (rs ? tick_now : press_prev);
        e_light = (k % LD) == 0;

        win.push_back(ks);
        if (win.size() > DB) void'(win.pop_front());
        all_opp = (win.size() == DB);
        foreach (win[i]) if (win[i] == acc) all_opp = 1'b0;
        press_now = all_opp && acc;
        if (all_opp) acc = !acc;
        press_prev = press_now;

        e_step  = !rs;
        e_quick = cs;
        rs_last = rs;
        cs_last = cs;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s at t=%0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cpu_ce", 32'(bus.cpu_ce), 32'(e_cpu));
        check("light_ce", 32'(bus.light_ce), 32'(e_light));
        check("step_led", 32'(bus.step_led), 32'(e_step));
        check("quick_low_led", 32'(bus.quick_low_led), 32'(e_quick));
        if (bus.cpu_ce === 1'b1) ce_count++;
    endtask

    int c0;
    int seg;
    bit lvl;

    initial begin
        model_reset();
        bus.SW_choose  = 1'b1;
        bus.SW_run     = 1'b1;
        bus.key_step_n = 1'b1;
        bus.halt       = 1'b0;
        rst_n          = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Fast free-run.
        repeat (40) tick();
        c0 = ce_count;
        repeat (40) tick();
        check("fast_run_pulses_40cyc", 32'(ce_count - c0), 32'd10);

        // Drop to slow mid-period.
        repeat (2) tick();
        bus.SW_choose = 1'b0;
        repeat (35) tick();

        // Step mode with a bouncing key, then a solid press.
        bus.SW_run = 1'b0;
        repeat (4) tick();
        c0 = ce_count;
        lvl = 1'b0;
        for (int b = 0; b < 6; b++) begin
            bus.key_step_n = lvl;
            seg = $urandom_range(1, 3);
            repeat (seg) tick();
            lvl = !lvl;
        end
        bus.key_step_n = 1'b0;
        repeat (20) tick();
        check("bounce_single_press", 32'(ce_count - c0), 32'd1);
        bus.key_step_n = 1'b1;
        repeat (12) tick();
        bus.key_step_n = 1'b0;
        repeat (12) tick();
        check("second_press", 32'(ce_count - c0), 32'd2);
        bus.key_step_n = 1'b1;
        repeat (10) tick();

        // Long hold yields one strobe only.
        c0 = ce_count;
        bus.key_step_n = 1'b0;
        repeat (100) tick();
        check("long_hold_single", 32'(ce_count - c0), 32'd1);
        bus.key_step_n = 1'b1;
        repeat (10) tick();

        // Halt in fast run mode.
        bus.SW_run = 1'b1;
        bus.SW_choose = 1'b1;
        repeat (8) tick();
        bus.halt = 1'b1;
        c0 = ce_count;
        repeat (20) tick();
        check("halted_no_ce", 32'(ce_count - c0), 32'd0);
        bus.halt = 1'b0;
        repeat (20) tick();

        // Reset mid-debounce in step mode: the pending press is lost.
        bus.SW_run = 1'b0;
        repeat (6) tick();
        bus.key_step_n = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.key_step_n = 1'b1;
        c0 = ce_count;
        repeat (12) tick();
        check("reset_discards_press", 32'(ce_count - c0), 32'd0);

        // Reset mid-count in run mode: both dividers restart.
        bus.SW_run = 1'b1;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();

        // Random soak.
        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 24) == 0) bus.SW_run = !bus.SW_run;
            if ($urandom_range(0, 29) == 0) bus.SW_choose = !bus.SW_choose;
            if ($urandom_range(0, 5) == 0) bus.key_step_n = !bus.key_step_n;
            bus.halt = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst_n = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
